// File: rtl/adc_sampler_pkg.sv
// adc_sampler_pkg: shared types and constants for the serial-ADC front end.
// Averaging depth is used only when ADC_SAMPLER_AVG_EN is defined.
package adc_sampler_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int AVG_DEPTH  = 4;
  localparam int AVG_LOG2   = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/adc_sclk_div.sv
// adc_sclk_div: half-period counter and adc_sclk toggle.
// rise/fall flag the clk cycle whose closing edge moves adc_sclk.
module adc_sclk_div #(
  parameter int SCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic halt,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          edge_en;

  assign edge_en = active && (cnt == LAST);
  assign rise    = edge_en && !sclk;
  assign fall    = edge_en && sclk;

  // halt suppresses the rise that would start a ninth bit
  always_ff @(posedge clk) begin
    if (!rst || !active || halt) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (edge_en) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/adc_sampler.sv
// adc_sampler: periodic serial-ADC capture into a held parallel word.
// Define ADC_SAMPLER_AVG_EN to report the mean of every 4 conversions.
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SCLK_DIV      = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              adc_sdo,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [0:DATA_W-1] adc_data,
  output logic              data_valid,
  output logic              busy
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W);

  state_t            state, state_n;
  logic [TW-1:0]     tmr;
  logic              tick;
  logic [DATA_W-1:0] sh, sh_n;
  logic [BW-1:0]     bcnt, bcnt_n;
  logic [DATA_W-1:0] data_n;
  logic              cs_n_n, busy_n, dv_n;
  logic              active, finish, rise, fall;

`ifdef ADC_SAMPLER_AVG_EN
  localparam logic [AVG_LOG2-1:0] GRP_LAST = AVG_LOG2'(AVG_DEPTH - 1);
  logic [DATA_W+1:0]   sum, sum_n, acc;
  logic [AVG_LOG2-1:0] grp, grp_n;
  assign acc = sum + (DATA_W+2)'(sh);
`endif

  assign tick   = (tmr == T_LAST);
  assign active = (state == SETUP) || (state == SHIFT);
  assign finish = (state == SHIFT) && rise && (bcnt == B_LAST);

  adc_sclk_div #(
    .SCLK_DIV(SCLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .active(active),
    .halt  (finish),
    .sclk  (adc_sclk),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (!rst || tick) tmr <= '0;
    else              tmr <= tmr + TW'(1);
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    bcnt_n  = bcnt;
    cs_n_n  = adc_cs_n;
    busy_n  = busy;
    dv_n    = 1'b0;
    data_n  = adc_data;
`ifdef ADC_SAMPLER_AVG_EN
    sum_n   = sum;
    grp_n   = grp;
`endif
    unique case (state)
      IDLE: begin
        bcnt_n = '0;
        if (tick && enable) begin
          state_n = SETUP;
          cs_n_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end
      SETUP: begin
        if (rise) begin
          sh_n    = {sh[DATA_W-2:0], adc_sdo};
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (fall) bcnt_n = bcnt + BW'(1);
        if (finish) begin
          state_n = DONE;
          cs_n_n  = 1'b1;
          busy_n  = 1'b0;
`ifdef ADC_SAMPLER_AVG_EN
          if (grp == GRP_LAST) begin
            data_n = acc[AVG_LOG2 +: DATA_W];
            dv_n   = 1'b1;
            sum_n  = '0;
            grp_n  = '0;
          end else begin
            sum_n  = acc;
            grp_n  = grp + AVG_LOG2'(1);
          end
`else
          data_n = sh;
          dv_n   = 1'b1;
`endif
        end else if (rise) begin
          sh_n = {sh[DATA_W-2:0], adc_sdo};
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sh         <= '0;
      bcnt       <= '0;
      adc_cs_n   <= 1'b1;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      adc_data   <= '0;
`ifdef ADC_SAMPLER_AVG_EN
      sum        <= '0;
      grp        <= '0;
`endif
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      bcnt       <= bcnt_n;
      adc_cs_n   <= cs_n_n;
      busy       <= busy_n;
      data_valid <= dv_n;
      adc_data   <= data_n;
`ifdef ADC_SAMPLER_AVG_EN
      sum        <= sum_n;
      grp        <= grp_n;
`endif
    end
  end

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: bench for adc_sampler with a serial ADC model and
// a frame-level scoreboard (mean of 4 frames when averaging is built in).
module tb_adc_sampler;

  localparam int DW    = 8;
  localparam int D     = 2;
  localparam int SP    = 64;
  localparam int CSLOW = 17 * D;
`ifdef ADC_SAMPLER_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic adc_sdo = 1'b0;
  logic adc_cs_n, adc_sclk, data_valid, busy;
  logic [0:DW-1] adc_data;

  adc_sampler #(
    .DATA_W(DW),
    .SCLK_DIV(D),
    .SAMPLE_PERIOD(SP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .adc_sdo(adc_sdo),
    .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk),
    .adc_data(adc_data),
    .data_valid(data_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // serial ADC: MSB ready at CS fall, next bit after each SCLK fall
  logic [7:0] frame_q[$];
  logic [7:0] started_q[$];
  logic [7:0] cur;
  int bitn = -1;

  always @(negedge adc_cs_n) begin
    if (frame_q.size() > 0) cur = frame_q.pop_front();
    else cur = 8'($urandom);
    started_q.push_back(cur);
    adc_sdo = cur[7];
    bitn = 6;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0 && bitn >= 0) begin
      adc_sdo = cur[bitn[2:0]];
      bitn--;
    end
  end

  // frame-level reference: each strobe reports the mean of the
  // last `need` completed frames (need = 1 without averaging)
  logic [7:0] held = 8'h00;
  logic [7:0] expv;
  int cyc = 0, cs_run = 0, last_cs_low = 0, falls = 0;
  int last_fall_cyc = 0, last_rise = 0, dv_seen = 0;
  int viol_hold = 0, viol_dv = 0, viol_sclk = 0;
  int need, s;
  logic prev_cs = 1'b1, prev_dv = 1'b0, prev_sclk = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      held = 8'h00;
      started_q.delete();
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (adc_cs_n === 1'b0) cs_run++;
    else if (cs_run > 0) begin
      last_cs_low = cs_run;
      cs_run = 0;
    end
    if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
      falls++;
      last_fall_cyc = cyc;
    end
    if (adc_cs_n !== 1'b0) begin
      last_rise = 0;
      if (adc_sclk !== 1'b0) viol_sclk++;
    end else if (adc_sclk === 1'b1 && prev_sclk === 1'b0) begin
      if (last_rise != 0 && cyc - last_rise != 2 * D) viol_sclk++;
      last_rise = cyc;
    end
    if (data_valid === 1'b1) begin
      if (prev_dv !== 1'b0 || prev_cs !== 1'b0 || adc_cs_n !== 1'b1)
        viol_dv++;
      dv_seen++;
      need = AVG ? 4 : 1;
      chk("sb_frames", 32'(started_q.size() >= need), 32'(1));
      if (started_q.size() >= need) begin
        s = 0;
        repeat (need) s += 32'(started_q.pop_front());
        expv = 8'(s / need);
        chk("sb_data", 32'(adc_data), 32'(expv));
        held = expv;
      end
    end else if (adc_data !== held) begin
      viol_hold++;
    end
    prev_cs = adc_cs_n;
    prev_dv = data_valid;
    prev_sclk = adc_sclk;
  end

  task automatic wait_cs(input logic lvl, input string nm);
    int n;
    n = 0;
    while (adc_cs_n !== lvl && n < 4 * SP) begin
      @(negedge clk);
      n++;
    end
    if (adc_cs_n !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: cs_n timeout got %b want %b", nm, adc_cs_n, lvl);
    end
  endtask

  typedef struct {
    logic [7:0] word;
    logic       dv;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[$];
  int prev_fall, d0, f0, n;

  initial begin
`ifdef ADC_SAMPLER_AVG_EN
    tbl.push_back('{8'd100, 1'b0, 8'd0});
    tbl.push_back('{8'd101, 1'b0, 8'd0});
    tbl.push_back('{8'd102, 1'b0, 8'd0});
    tbl.push_back('{8'd103, 1'b1, 8'd101});
    tbl.push_back('{8'd255, 1'b0, 8'd101});
    tbl.push_back('{8'd255, 1'b0, 8'd101});
    tbl.push_back('{8'd255, 1'b0, 8'd101});
    tbl.push_back('{8'd255, 1'b1, 8'd255});
    tbl.push_back('{8'd0,   1'b0, 8'd255});
    tbl.push_back('{8'd1,   1'b0, 8'd255});
    tbl.push_back('{8'd2,   1'b0, 8'd255});
    tbl.push_back('{8'd3,   1'b1, 8'd1});
`else
    tbl.push_back('{8'hC8, 1'b1, 8'hC8});
    tbl.push_back('{8'h64, 1'b1, 8'd100});
    tbl.push_back('{8'hFA, 1'b1, 8'd250});
    tbl.push_back('{8'hFF, 1'b1, 8'hFF});
    tbl.push_back('{8'h00, 1'b1, 8'h00});
    tbl.push_back('{8'h01, 1'b1, 8'h01});
    tbl.push_back('{8'h80, 1'b1, 8'h80});
    tbl.push_back('{8'hA5, 1'b1, 8'hA5});
`endif

    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(adc_cs_n), 32'(1));
    chk("rst_sclk", 32'(adc_sclk), 32'(0));
    chk("rst_data", 32'(adc_data), 32'(0));
    chk("rst_dv", 32'(data_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b1;
    enable = 1'b1;

    prev_fall = 0;
    foreach (tbl[i]) begin
      frame_q.push_back(tbl[i].word);
      wait_cs(1'b0, "tbl_fall");
      #1;
      chk("tbl_busy", 32'(busy), 32'(1));
      if (i > 0) chk("tbl_period", 32'(last_fall_cyc - prev_fall), 32'(SP));
      prev_fall = last_fall_cyc;
      wait_cs(1'b1, "tbl_rise");
      #1;
      chk("tbl_dv", 32'(data_valid), 32'(tbl[i].dv));
      chk("tbl_data", 32'(adc_data), 32'(tbl[i].data));
      chk("tbl_cs_low", 32'(last_cs_low), 32'(CSLOW));
      chk("tbl_busy_end", 32'(busy), 32'(0));
    end

    // reset in the middle of bit 5 aborts the frame
    frame_q.push_back(8'h3C);
    wait_cs(1'b0, "rst_fall");
    repeat (9 * D) @(negedge clk);
    d0 = dv_seen;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_cs_n", 32'(adc_cs_n), 32'(1));
    chk("abort_sclk", 32'(adc_sclk), 32'(0));
    chk("abort_data", 32'(adc_data), 32'(0));
    chk("abort_dv", 32'(data_valid), 32'(0));
    rst = 1'b1;
    frame_q.push_back(8'h5A);
    n = 0;
    while (adc_cs_n !== 1'b0 && n < 4 * SP) begin
      @(negedge clk);
      n++;
    end
    chk("abort_next_tick", 32'(n), 32'(SP));
    chk("abort_no_dv", 32'(dv_seen - d0), 32'(0));
    wait_cs(1'b1, "clean_rise");
    #1;
    chk("clean_dv", 32'(data_valid), AVG ? 32'(0) : 32'(1));
    chk("clean_data", 32'(adc_data), AVG ? 32'(0) : 32'(8'h5A));

    // enable dropped mid-frame: frame completes, no new frames
    frame_q.push_back(8'h3A);
    wait_cs(1'b0, "en_fall");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_cs(1'b1, "en_rise");
    #1;
    chk("en_dv", 32'(data_valid), AVG ? 32'(0) : 32'(1));
    chk("en_data", 32'(adc_data), AVG ? 32'(0) : 32'(8'h3A));
    chk("en_cs_low", 32'(last_cs_low), 32'(CSLOW));
    f0 = falls;
    repeat (3 * SP) @(negedge clk);
    chk("en_no_frames", 32'(falls - f0), 32'(0));
    enable = 1'b1;

    // random frames, checked by the scoreboard
    d0 = dv_seen;
    repeat (16) begin
      frame_q.push_back(8'($urandom));
      wait_cs(1'b0, "rnd_fall");
      wait_cs(1'b1, "rnd_rise");
      #1;
    end
    @(negedge clk);
    #1;
    chk("rnd_strobes", 32'(dv_seen - d0), AVG ? 32'(4) : 32'(16));
    chk("hold_viol", 32'(viol_hold), 32'(0));
    chk("dv_shape_viol", 32'(viol_dv), 32'(0));
    chk("sclk_viol", 32'(viol_sclk), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sampler.md
# adc_sampler

Serial-ADC front end that produces the 8-bit parallel `ADC` temperature word consumed by the temperature `controller`. It periodically starts a conversion on an external SPI-style ADC and clocks in 8 serial bits, MSB first. It then presents the result as a held parallel word with a one-cycle `data_valid` strobe. It is the producing end of the `ADC[0:7]` bus.

## Interface
Parameters:
- `DATA_W`, 8: conversion width in bits.
- `SCLK_DIV`, 4: clk cycles per `adc_sclk` half-period. Must be ≥ 1.
- `SAMPLE_PERIOD`, 1000: clk cycles between conversion starts. Must be ≥ 17*`SCLK_DIV`+2.

Ports:
- `clk`, in, 1: single clock; all logic on the posedge.
- `rst`, in, 1: reset, synchronous, active-low.
- `enable`, in, 1: when 1, sample ticks start conversions.
- `adc_sdo`, in, 1: serial data from the ADC. The ADC changes it after each falling edge of `adc_sclk`.
- `adc_cs_n`, out, 1: ADC chip select, active-low.
- `adc_sclk`, out, 1: ADC serial clock; idles low.
- `adc_data`, out, [0:DATA_W-1]: last completed conversion. Bit 0 is the MSB. Feeds `controller.ADC`.
- `data_valid`, out, 1: one-cycle strobe when `adc_data` updates.
- `busy`, out, 1: high while a conversion is in progress.

## Operation
- Reset (`rst`=0 at a posedge):
  - `adc_cs_n`=1, `adc_sclk`=0, `adc_data`=0, `data_valid`=0, `busy`=0.
  - Sample timer = 0, state = IDLE.
  - Reset mid-conversion aborts it with no `data_valid` and no `adc_data` update.
- Sample timer:
  - Free-running, counts 0..SAMPLE_PERIOD-1 and wraps.
  - The tick is the cycle with count = SAMPLE_PERIOD-1.
  - A tick while `enable`=0 or `busy`=1 is dropped, not queued.
- FSM states IDLE → SETUP → SHIFT → DONE → IDLE:
  - IDLE: on tick with `enable`=1, go to SETUP. `adc_cs_n`←0, `busy`←1.
  - SETUP: `SCLK_DIV` cycles with `adc_sclk` low, then SHIFT.
  - SHIFT: `DATA_W` bits. Each bit is `SCLK_DIV` cycles with `adc_sclk` high followed by `SCLK_DIV` cycles low. On the clk edge that drives `adc_sclk` 0→1, `adc_sdo` is captured into the shift register, MSB first. After the last low phase, go to DONE.
  - DONE: one cycle. `adc_cs_n`←1, `busy`←0, `adc_data`←shift register, `data_valid`←1. Then IDLE.
- Deasserting `enable` mid-conversion has no effect on that conversion; it completes normally.
- `adc_data` holds its value between updates and is never partially updated.

## Timing
- `adc_cs_n` is low for exactly 17*SCLK_DIV cycles, i.e. (2*DATA_W+1)*SCLK_DIV.
- `data_valid` rises in the same cycle `adc_cs_n` returns high.
- Tick-to-`data_valid` latency is 17*SCLK_DIV+1 cycles.
- `adc_sclk` period is 2*SCLK_DIV clk cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `ADC_SAMPLER_AVG_EN` defined:
  - Completed conversions accumulate into a (DATA_W+2)-bit sum.
  - After every 4th conversion, `adc_data` ← sum>>2 (truncated), `data_valid` pulses, and the sum clears.
  - Conversions 1–3 of each group produce no strobe.
  - Reset clears the sum and the group count.
- Not defined: every conversion updates `adc_data` and strobes `data_valid`.

## Structure
- Package `adc_sampler_pkg` holds:
  - the FSM state enum (IDLE, SETUP, SHIFT, DONE);
  - the `DATA_W` default;
  - the averaging depth constant (4) and its log2 (2).
- Sub-module `adc_sclk_div` contains the half-period counter and the `adc_sclk` toggle. It outputs `rise` and `fall` enables to the FSM.
- The shift register, FSM, sample timer and averager live in `adc_sampler`.

## Test plan
All scenarios use SCLK_DIV=2 and SAMPLE_PERIOD=64 unless stated otherwise.

1. Drive `adc_sdo` with serial 0xC8. Expect `adc_data`=0xC8 (200), a single `data_valid` pulse, and `adc_cs_n` low for exactly 34 cycles.
2. Back-to-back frames 0x64 then 0xFA. Expect `data_valid` pulses 64 cycles apart carrying 100 then 250, and `adc_data` holding 100 between the pulses.
3. Pulse `rst`=0 for one cycle in the 5th bit of a frame. Next cycle expect `adc_cs_n`=1, `adc_sclk`=0, `adc_data`=0, and no `data_valid`. The next tick starts a clean frame.
4. Drop `enable` mid-frame: that frame completes with a strobe, and no further `adc_cs_n` falls while `enable`=0.
5. With `ADC_SAMPLER_AVG_EN`, frames 100, 101, 102, 103: exactly one `data_valid`, after the 4th frame, with `adc_data`=101 (406>>2).
6. Frame of 0xFF then 0x00: checks the MSB-first bit order and the full range, giving `adc_data`=0xFF then 0x00.
